// File: rtl/vpifo_pop_scheduler.sv
// Round-robin pop scheduler for the multi-tree SRAM PIFO, with a credit-protected FWFT output FIFO.
// Optional macro VPIFO_POP_WEIGHT_EN adds i_weight (4b burst weight per tree, 0 treated as 1).
module vpifo_pop_scheduler #(
  parameter int PTW           = 16,
  parameter int TREE_NUM      = 6,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int CNT_W         = 12,
  parameter int POP_LAT       = 2,
  parameter int OUT_DEPTH     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push_seen,
  input  logic [TREE_NUM_BITS-1:0] i_push_tree,
  input  logic                     i_task_fifo_full,
  output logic                     o_pop,
  output logic [TREE_NUM_BITS-1:0] o_pop_tree,
  input  logic [PTW-1:0]           i_pop_data,
`ifdef VPIFO_POP_WEIGHT_EN
  input  logic [4*TREE_NUM-1:0]    i_weight,
`endif
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [PTW-1:0]           o_out_data,
  output logic [TREE_NUM_BITS-1:0] o_out_tree,
  output logic [TREE_NUM-1:0]      o_empty,
  output logic                     o_err
);

  localparam int AW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCW = $clog2(OUT_DEPTH + 1);
  localparam int CW  = $clog2(OUT_DEPTH + POP_LAT + 2) + 1;
  localparam int TW  = TREE_NUM_BITS + 1;
  localparam int EW  = TREE_NUM_BITS + PTW;

  function automatic logic [TREE_NUM_BITS-1:0] wrap_inc(input logic [TREE_NUM_BITS-1:0] v);
    return (v == TREE_NUM_BITS'(TREE_NUM - 1)) ? '0 : v + TREE_NUM_BITS'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OUT_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  logic [CNT_W-1:0]         cnt_q [TREE_NUM];
  logic [CNT_W-1:0]         cnt_d [TREE_NUM];
  logic [TREE_NUM_BITS-1:0] rr_q, rr_d;
  logic                     pop_q, pop_d;
  logic [TREE_NUM_BITS-1:0] pop_tree_q, pop_tree_d;
  logic [POP_LAT-1:0]       dl_valid_q, dl_valid_d;
  logic [TREE_NUM_BITS-1:0] dl_tree_q [POP_LAT];
  logic [TREE_NUM_BITS-1:0] dl_tree_d [POP_LAT];
  logic [EW-1:0]            mem_q [OUT_DEPTH];
  logic [EW-1:0]            mem_d [OUT_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [OCW-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic                     err_q, err_d;

  logic [TREE_NUM-1:0]      elig;
  logic [TW-1:0]            cand;
  logic                     grant_found;
  logic [TREE_NUM_BITS-1:0] grant;
  logic [CW-1:0]            inflight;
  logic [CW-1:0]            outstanding;
  logic                     credit;
  logic                     issue;
  logic                     rd_fire;
  logic                     wr_fire;
  logic                     push_ok;
  logic [TREE_NUM-1:0]      inc_vec;
  logic [TREE_NUM-1:0]      dec_vec;

  always_comb begin
    elig = '0;
    for (int t = 0; t < TREE_NUM; t++) elig[t] = (cnt_q[t] != '0);
  end

  assign o_empty = ~elig;

  // Scan offsets from the far end so the eligible tree nearest the pointer wins.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int i = TREE_NUM - 1; i >= 0; i--) begin
      cand = {1'b0, rr_q} + TW'(i);
      if (cand >= TW'(TREE_NUM)) cand = cand - TW'(TREE_NUM);
      if (elig[cand[TREE_NUM_BITS-1:0]]) begin
        grant_found = 1'b1;
        grant       = cand[TREE_NUM_BITS-1:0];
      end
    end
  end

  // Outstanding work covers the issued pop, the delay line and the FIFO; a word leaving now frees its slot.
  always_comb begin
    rd_fire  = (fifo_cnt_q != '0) && i_out_ready;
    wr_fire  = dl_valid_q[POP_LAT-1];
    inflight = CW'(pop_q);
    for (int s = 0; s < POP_LAT; s++) inflight = inflight + CW'(dl_valid_q[s]);
    outstanding = inflight + CW'(fifo_cnt_q) - CW'(rd_fire);
    credit      = (outstanding < CW'(OUT_DEPTH));
    issue       = grant_found && !i_task_fifo_full && credit;
  end

  always_comb begin
    err_d   = err_q;
    push_ok = i_push_seen && ({1'b0, i_push_tree} < TW'(TREE_NUM));
    inc_vec = '0;
    dec_vec = '0;
    if (i_push_seen && !push_ok) err_d = 1'b1;
    for (int t = 0; t < TREE_NUM; t++) begin
      cnt_d[t]   = cnt_q[t];
      inc_vec[t] = push_ok && (i_push_tree == TREE_NUM_BITS'(t));
      dec_vec[t] = issue && (grant == TREE_NUM_BITS'(t));
      if (inc_vec[t] && !dec_vec[t]) begin
        if (&cnt_q[t]) err_d = 1'b1;
        else           cnt_d[t] = cnt_q[t] + CNT_W'(1);
      end else if (dec_vec[t] && !inc_vec[t]) begin
        cnt_d[t] = cnt_q[t] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    pop_d      = issue;
    pop_tree_d = issue ? grant : pop_tree_q;
  end

`ifdef VPIFO_POP_WEIGHT_EN
  logic [3:0] burst_q, burst_d, burst_next, grant_w;

  // The pointer parks on the granted tree until its burst is used up, it empties, or issue stalls.
  always_comb begin
    grant_w = 4'd1;
    for (int t = 0; t < TREE_NUM; t++) begin
      if ((grant == TREE_NUM_BITS'(t)) && (i_weight[4*t +: 4] != 4'd0)) grant_w = i_weight[4*t +: 4];
    end
    burst_next = ((grant == rr_q) ? burst_q : 4'd0) + 4'd1;
    rr_d       = rr_q;
    burst_d    = burst_q;
    if (issue) begin
      if (burst_next >= grant_w) begin
        rr_d    = wrap_inc(grant);
        burst_d = '0;
      end else begin
        rr_d    = grant;
        burst_d = burst_next;
      end
    end else if (burst_q != '0) begin
      rr_d    = wrap_inc(rr_q);
      burst_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) burst_q <= '0;
    else       burst_q <= burst_d;
  end
`else
  always_comb begin
    rr_d = rr_q;
    if (issue) rr_d = wrap_inc(grant);
  end
`endif

  always_comb begin
    dl_valid_d[0] = pop_q;
    dl_tree_d[0]  = pop_tree_q;
    for (int s = 1; s < POP_LAT; s++) begin
      dl_valid_d[s] = dl_valid_q[s-1];
      dl_tree_d[s]  = dl_tree_q[s-1];
    end
  end

  always_comb begin
    for (int e = 0; e < OUT_DEPTH; e++) mem_d[e] = mem_q[e];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (wr_fire) begin
      mem_d[wr_ptr_q] = {dl_tree_q[POP_LAT-1], i_pop_data};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (wr_fire && !rd_fire)      fifo_cnt_d = fifo_cnt_q + OCW'(1);
    else if (!wr_fire && rd_fire) fifo_cnt_d = fifo_cnt_q - OCW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int t = 0; t < TREE_NUM; t++) cnt_q[t] <= '0;
      rr_q       <= '0;
      pop_q      <= 1'b0;
      pop_tree_q <= '0;
      dl_valid_q <= '0;
      for (int s = 0; s < POP_LAT; s++) dl_tree_q[s] <= '0;
      for (int e = 0; e < OUT_DEPTH; e++) mem_q[e] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int t = 0; t < TREE_NUM; t++) cnt_q[t] <= cnt_d[t];
      rr_q       <= rr_d;
      pop_q      <= pop_d;
      pop_tree_q <= pop_tree_d;
      dl_valid_q <= dl_valid_d;
      for (int s = 0; s < POP_LAT; s++) dl_tree_q[s] <= dl_tree_d[s];
      for (int e = 0; e < OUT_DEPTH; e++) mem_q[e] <= mem_d[e];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      err_q      <= err_d;
    end
  end

  assign o_pop       = pop_q;
  assign o_pop_tree  = pop_tree_q;
  assign o_err       = err_q;
  assign o_out_valid = (fifo_cnt_q != '0);
  assign {o_out_tree, o_out_data} = o_out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_vpifo_pop_scheduler.sv
// Scoreboard bench for vpifo_pop_scheduler: a queue-based reference model predicts pops and outputs.
module tb_vpifo_pop_scheduler;

  localparam int PTW       = 16;
  localparam int TREE_NUM  = 6;
  localparam int TNB       = 3;
  localparam int CNT_MAX   = 4095;
  localparam int POP_LAT   = 2;
  localparam int OUT_DEPTH = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_push_seen;
  logic [TNB-1:0]   i_push_tree;
  logic             i_task_fifo_full;
  logic             o_pop;
  logic [TNB-1:0]   o_pop_tree;
  logic [PTW-1:0]   i_pop_data;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [PTW-1:0]   o_out_data;
  logic [TNB-1:0]   o_out_tree;
  logic [TREE_NUM-1:0] o_empty;
  logic             o_err;
`ifdef VPIFO_POP_WEIGHT_EN
  logic [4*TREE_NUM-1:0] i_weight = '0;
`endif

  vpifo_pop_scheduler dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_push_seen      (i_push_seen),
    .i_push_tree      (i_push_tree),
    .i_task_fifo_full (i_task_fifo_full),
    .o_pop            (o_pop),
    .o_pop_tree       (o_pop_tree),
    .i_pop_data       (i_pop_data),
`ifdef VPIFO_POP_WEIGHT_EN
    .i_weight         (i_weight),
`endif
    .o_out_valid      (o_out_valid),
    .i_out_ready      (i_out_ready),
    .o_out_data       (o_out_data),
    .o_out_tree       (o_out_tree),
    .o_empty          (o_empty),
    .o_err            (o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct { int tree; int due; } pend_t;
  typedef struct { int tree; int data; } out_t;

  // Reference model: plain integer counts, a list of outstanding pops with their data-return edge,
  // and the queue of entries the DUT owes on its output stream.
  int    m_cnt [TREE_NUM];
  int    m_rr       = 0;
  int    m_fifo     = 0;
  int    m_cyc      = 0;
  bit    m_pop      = 1'b0;
  int    m_pop_tree = 0;
  bit    m_err      = 1'b0;
  bit    m_rst_seen = 1'b0;
  int    m_g;
  bit    m_rd;
  bit    m_issue;
  int    m_push_t;
  pend_t m_pend [$];
  out_t  exp_q [$];
  logic [TREE_NUM-1:0] exp_empty;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, m_cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit push, input int tree, input bit full, input bit ready);
    i_rst            = rst;
    i_push_seen      = push;
    i_push_tree      = TNB'(tree);
    i_task_fifo_full = full;
    i_out_ready      = ready;
    i_pop_data       = PTW'($urandom);
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle(input int n, input bit full, input bit ready);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, full, ready);
  endtask

  // Model advances on every rising edge from the inputs the bench is driving.
  always @(posedge i_clk) begin
    m_cyc++;
    if (i_rst) begin
      for (int t = 0; t < TREE_NUM; t++) m_cnt[t] = 0;
      m_rr = 0; m_fifo = 0; m_pop = 1'b0; m_pop_tree = 0; m_err = 1'b0;
      m_pend.delete();
      exp_q.delete();
      m_rst_seen = 1'b1;
    end else begin
      m_rst_seen = 1'b0;
      m_rd = (m_fifo > 0) && i_out_ready;
      m_g  = -1;
      for (int i = 0; i < TREE_NUM; i++)
        if (m_g < 0 && m_cnt[(m_rr + i) % TREE_NUM] != 0) m_g = (m_rr + i) % TREE_NUM;
      m_issue = (m_g >= 0) && !i_task_fifo_full &&
                (m_pend.size() + m_fifo - int'(m_rd) < OUT_DEPTH);
      if (m_pend.size() > 0 && m_pend[0].due == m_cyc) begin
        exp_q.push_back('{tree: m_pend[0].tree, data: int'(i_pop_data)});
        void'(m_pend.pop_front());
        m_fifo++;
      end
      if (m_rd) m_fifo--;
      m_push_t = -1;
      if (i_push_seen) begin
        if (int'(i_push_tree) >= TREE_NUM) m_err = 1'b1;
        else m_push_t = int'(i_push_tree);
      end
      if (m_issue) begin
        m_cnt[m_g]--;
        m_rr = (m_g + 1) % TREE_NUM;
        m_pend.push_back('{tree: m_g, due: m_cyc + 1 + POP_LAT});
        m_pop_tree = m_g;
      end
      if (m_push_t >= 0) begin
        if (m_issue && m_g == m_push_t) m_cnt[m_push_t]++;
        else if (m_cnt[m_push_t] == CNT_MAX) m_err = 1'b1;
        else m_cnt[m_push_t]++;
      end
      m_pop = m_issue;
    end
  end

  // Monitor: compares control outputs each cycle and pops the scoreboard on every output handshake.
  always @(negedge i_clk) begin
    if (m_cyc > 0) begin
      checkOutput("pop", o_pop, m_pop);
      if (m_pop && o_pop) checkOutput("pop_tree", o_pop_tree, m_pop_tree);
      for (int t = 0; t < TREE_NUM; t++) exp_empty[t] = (m_cnt[t] == 0);
      checkOutput("empty", o_empty, exp_empty);
      checkOutput("err", o_err, m_err);
      checkOutput("out_valid", o_out_valid, m_fifo != 0);
      if (m_rst_seen) begin
        checkOutput("rst_pop_tree", o_pop_tree, 0);
        checkOutput("rst_out_data", o_out_data, 0);
        checkOutput("rst_out_tree", o_out_tree, 0);
      end
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("out_unexpected", 1, 0);
        end else begin
          checkOutput("out_tree", o_out_tree, exp_q[0].tree);
          checkOutput("out_data", o_out_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_push_seen = 1'b0; i_push_tree = '0;
    i_task_fifo_full = 1'b0; i_out_ready = 1'b0; i_pop_data = '0;

    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Queue work while the PIFO reports full, then release to see the round-robin order.
    applyStimulus(1'b0, 1'b1, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 2, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 2, 1'b1, 1'b1);
    idle(12, 1'b0, 1'b1);

    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b0);
    idle(10, 1'b0, 1'b0);
    idle(20, 1'b0, 1'b1);

    applyStimulus(1'b0, 1'b1, 3, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 3, 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);
    idle(8, 1'b0, 1'b1);

    applyStimulus(1'b0, 1'b1, 4, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 4, 1'b0, 1'b1);
    idle(2, 1'b1, 1'b1);
    idle(6, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 7, 1'b0, 1'b1);
    idle(3, 1'b0, 1'b1);

    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1);
    idle(8, 1'b0, 1'b1);

    for (int k = 0; k < CNT_MAX + 2; k++) applyStimulus(1'b0, 1'b1, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b1);

    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 49) == 0) ? $urandom_range(6, 7) : $urandom_range(0, TREE_NUM - 1),
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) != 0);
    end

    for (int k = 0; k < 8; k++) idle(1, 1'b0, 1'b1);
    for (int t = 0; t < TREE_NUM; t++) begin
      while (m_cnt[t] != 0 && m_cyc < 20000) idle(1, 1'b0, 1'b1);
    end
    idle(10, 1'b0, 1'b1);
    checkOutput("drain_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
